// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default line parameters
// and the clocks-per-bit helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BAUD_RATE  = 9600;
  localparam int DEF_CLK_FREQ   = 100_000_000;

  function automatic int pulse_width(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: 'half' marks mid-bit after a clear, 'tick' marks the end
// of every full PULSE_WIDTH period.
module uart_baud_cnt #(
  parameter int PULSE_WIDTH = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic half,
  output logic tick
);

  localparam int CW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] MID  = CW'(PULSE_WIDTH / 2 - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap at the last clock of the period, restart on clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign half = (cnt_q == MID);
  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver with valid/ready output and frame-error / overrun pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BAUD_RATE  = DEF_BAUD_RATE,
  parameter int CLK_FREQ   = DEF_CLK_FREQ
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int PW = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [1:0]            sync_q, sync_d;
  rx_state_t             state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d;
  logic                  parity_err_q, parity_err_d;
`endif
  logic                  rs;
  logic                  clr;
  logic                  half;
  logic                  tick;
  logic                  frame_ok;

  uart_baud_cnt #(.PULSE_WIDTH(PW)) u_baud (
    .clk  (clk),
    .rstn (rstn),
    .clr  (clr),
    .half (half),
    .tick (tick)
  );

  assign rs = sync_q[1];

  // Receive FSM, shifter and output handshake.
  always_comb begin
    sync_d      = {sync_q[0], rx_sig};
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    data_d      = data_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    clr         = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
    frame_ok     = rs && !par_bad_q;
`else
    frame_ok     = rs;
`endif
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        if (!rs) begin
          state_d = START;
          clr     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (half) begin
          if (!rs) begin
            state_d = DATA;
            clr     = 1'b1;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rs, shift_q[DATA_WIDTH-1:1]};
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_bad_d = ^{shift_q, rs};
          state_d   = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d     = IDLE;
          frame_err_d = !rs;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
          // A completed byte is kept only if the output slot is free this cycle.
          if (frame_ok) begin
            if (!valid_q || ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            data_d = data_q;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q       <= 2'b11;
      state_q      <= IDLE;
      bit_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a frame-level model queues expected events,
// and a monitor pops and compares them as the receiver reports outputs.
module tb_uart_rx;

  localparam int DW     = 8;
  localparam int BAUD   = 9600;
  localparam int CLKF   = 153_600;
  localparam int PW     = CLKF / BAUD;
  localparam int K_ACC  = 0;
  localparam int K_FERR = 1;
  localparam int K_OVR  = 2;
  localparam int K_PERR = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_sig;
  logic          ready;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  ev_t        exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         pend;
  logic [7:0] pend_data;

  always #5 clk = ~clk;

  uart_rx #(.DATA_WIDTH(DW), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx_sig    (rx_sig),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int kind, input logic [7:0] d);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d data=%02h, expected none", kind, d);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != kind) || (e.data !== d)) begin
        n_err++;
        $display("FAIL event: got kind=%0d data=%02h, expected kind=%0d data=%02h",
                 kind, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: every reported output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (rstn) begin
      if (valid && ready) observe(K_ACC, data);
      if (frame_err) observe(K_FERR, 8'h00);
      if (overrun) observe(K_OVR, 8'h00);
`ifdef UART_RX_PARITY_EN
      if (parity_err) observe(K_PERR, 8'h00);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Frame-level reference: what the consumer should see for one frame.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    if (!stop_ok) push_ev(K_FERR, 8'h00);
    if (!par_ok) push_ev(K_PERR, 8'h00);
    if (stop_ok && par_ok) begin
      if (ready) begin
        push_ev(K_ACC, b);
      end else if (pend) begin
        push_ev(K_OVR, 8'h00);
      end else begin
        pend      = 1'b1;
        pend_data = b;
      end
    end
  endtask

  task automatic set_ready(input logic v);
    if (v && pend) begin
      push_ev(K_ACC, pend_data);
      pend = 1'b0;
    end
    ready = v;
  endtask

  task automatic drive_bit(input logic v);
    rx_sig = v;
    repeat (PW) tick();
  endtask

  task automatic idle(input int nbits);
    repeat (nbits) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    model_frame(b, stop_ok, par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ !par_ok);
`endif
    drive_bit(stop_ok);
  endtask

  task automatic glitch(input int len);
    rx_sig = 1'b0;
    repeat (len) tick();
    rx_sig = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    bit         s_ok;
    bit         p_ok;
    rstn   = 1'b0;
    rx_sig = 1'b1;
    ready  = 1'b1;
    pend   = 1'b0;
    repeat (5) tick();
    check("reset_valid", valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    check("reset_data", data, 0);
    rstn = 1'b1;
    idle(1);

    send_frame(8'hA5, 1'b1, 1'b1);
    idle(2);

    glitch(5);
    idle(2);
    check("glitch_valid", valid, 0);

    send_frame(8'h3C, 1'b0, 1'b1);
    idle(2);
    check("bad_stop_valid", valid, 0);

    set_ready(1'b0);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(1);
    check("overrun_data", data, {24'h0, pend_data});
    check("overrun_valid", valid, {31'h0, pend});
    set_ready(1'b1);
    repeat (3) tick();
    check("ready_clears_valid", valid, 0);

    // Aborted 0x5A: start and bits 0..3, reset during bit 4, line left idle.
    b = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx_sig = b[4];
    repeat (PW / 2) tick();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    pend = 1'b0;
    idle(1);
    check("abort_valid", valid, 0);
    check("abort_data_cleared", data, 0);
    idle(11);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(1);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(1);
    check("parity_bad_valid", valid, 0);
`endif

    for (int n = 0; n < 30; n++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        glitch(int'($urandom_range(1, 5)));
        idle(1);
      end else begin
        b    = 8'($urandom);
        s_ok = (r != 1);
`ifdef UART_RX_PARITY_EN
        p_ok = (r != 2);
`else
        p_ok = 1'b1;
`endif
        send_frame(b, s_ok, p_ok);
        if (!s_ok) idle(1 + int'($urandom_range(0, 2)));
        else idle(int'($urandom_range(0, 2)));
      end
    end

    for (int i = 0; (i < 4 * PW) && (exp_q.size() != 0); i++) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
